// File: rtl/cam_capture_ctrl_if.sv
// Camera capture bus: sensor byte stream, arming controls and assembled pixel outputs.
interface cam_capture_ctrl_if #(
    parameter int unsigned DW        = 8,
    parameter int unsigned PIX_BYTES = 2,
    parameter int unsigned XW        = 11,
    parameter int unsigned YW        = 10,
    parameter int unsigned FCW       = 32
);
    logic [DW-1:0]           iDATA;
    logic                    iFVAL;
    logic                    iLVAL;
    logic                    iSTART;
    logic                    iEND;
    logic                    iSINGLE;
    logic [PIX_BYTES*DW-1:0] oDATA;
    logic                    oDVAL;
    logic                    oSOF;
    logic                    oEOL;
    logic                    oEOF;
    logic [XW-1:0]           oX_Cont;
    logic [YW-1:0]           oY_Cont;
    logic [FCW-1:0]          oFrame_Cont;
    logic                    oBUSY;
    logic                    oLINE_ERR;
    logic                    oFRAME_ERR;

    modport slave (
        input  iDATA, iFVAL, iLVAL, iSTART, iEND, iSINGLE,
        output oDATA, oDVAL, oSOF, oEOL, oEOF, oX_Cont, oY_Cont,
               oFrame_Cont, oBUSY, oLINE_ERR, oFRAME_ERR
    );

    modport master (
        output iDATA, iFVAL, iLVAL, iSTART, iEND, iSINGLE,
        input  oDATA, oDVAL, oSOF, oEOL, oEOF, oX_Cont, oY_Cont,
               oFrame_Cont, oBUSY, oLINE_ERR, oFRAME_ERR
    );
endinterface

// File: rtl/cam_capture_ctrl.sv
// Camera-bus capture front end: assembles FVAL/LVAL-qualified bytes into pixels with
// coordinates, frame markers, start/stop/single-shot arming and geometry-error flags.
module cam_capture_ctrl #(
    parameter int unsigned DW        = 8,
    parameter int unsigned PIX_BYTES = 2,
    parameter int unsigned H_ACTIVE  = 640,
    parameter int unsigned V_ACTIVE  = 480,
    parameter int unsigned XW        = 11,
    parameter int unsigned YW        = 10,
    parameter int unsigned FCW       = 32
) (
    input  logic               iCLK,
    input  logic               iRST,
    cam_capture_ctrl_if.slave  bus
);
    localparam int unsigned    PW      = PIX_BYTES * DW;
    localparam int unsigned    PHW     = (PIX_BYTES > 1) ? $clog2(PIX_BYTES) : 1;
    localparam logic [PHW-1:0] PH_LAST = PHW'(PIX_BYTES - 1);
    localparam logic [XW-1:0]  X_MAX   = XW'(H_ACTIVE);
    localparam logic [YW-1:0]  Y_MAX   = YW'(V_ACTIVE);

    typedef enum logic [1:0] {S_IDLE, S_ARMED, S_CAPT} state_t;

    state_t         r_state;
    logic           r_single;
    logic           r_stop;
    logic           r_pfval;
    logic [DW-1:0]  r_ds;
    logic           r_ls;
    logic           r_ls_d;
    logic           r_in_line;
    logic [PHW-1:0] r_ph;
    logic [PW-1:0]  r_asm;
    logic [XW-1:0]  r_x;
    logic [YW-1:0]  r_y;
    logic           r_x_ovf;
    logic           r_y_ovf;
    logic           r_sof_pend;
    logic [PW-1:0]  r_data;
    logic           r_dval;
    logic           r_sof;
    logic           r_eol;
    logic           r_eof;
    logic [XW-1:0]  r_x_cont;
    logic [YW-1:0]  r_y_cont;
    logic [FCW-1:0] r_frame_cnt;
    logic           r_busy;
    logic           r_line_err;
    logic           r_frame_err;

    logic           w_fs;
    logic           w_fe;
    logic           w_capt;
    logic           w_rise;
    logic           w_fall;
    logic           w_byte;
    logic           w_pix;
    logic           w_eol;
    logic           w_in_win;
    logic [PW-1:0]  w_asm_next;

    // VSYNC is high between frames: its falling edge opens a frame, its rising edge closes it
    assign w_fs       = r_pfval & ~bus.iFVAL;
    assign w_fe       = ~r_pfval & bus.iFVAL;
    assign w_capt     = (r_state == S_CAPT);
    assign w_rise     = r_ls & ~r_ls_d;
    assign w_fall     = ~r_ls & r_ls_d;
    // A line only opens on an lS rising edge seen in CAPT; bytes of a line already running are ignored
    assign w_byte     = w_capt & r_ls & (r_in_line | w_rise);
    assign w_pix      = w_byte & (r_ph == PH_LAST);
    assign w_eol      = w_capt & w_fall & (r_x != '0);
    assign w_in_win   = (r_x < X_MAX) & (r_y < Y_MAX);
    assign w_asm_next = (r_asm << DW) | PW'(r_ds);

    always_ff @(posedge iCLK or negedge iRST) begin
        if (!iRST) begin
            r_state     <= S_IDLE;
            r_single    <= 1'b0;
            r_stop      <= 1'b0;
            r_pfval     <= 1'b0;
            r_ds        <= '0;
            r_ls        <= 1'b0;
            r_ls_d      <= 1'b0;
            r_in_line   <= 1'b0;
            r_ph        <= '0;
            r_asm       <= '0;
            r_x         <= '0;
            r_y         <= '0;
            r_x_ovf     <= 1'b0;
            r_y_ovf     <= 1'b0;
            r_sof_pend  <= 1'b0;
            r_data      <= '0;
            r_dval      <= 1'b0;
            r_sof       <= 1'b0;
            r_eol       <= 1'b0;
            r_eof       <= 1'b0;
            r_x_cont    <= '0;
            r_y_cont    <= '0;
            r_frame_cnt <= '0;
            r_busy      <= 1'b0;
            r_line_err  <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_pfval <= bus.iFVAL;
            r_ds    <= bus.iDATA;
            r_ls    <= bus.iLVAL;
            r_ls_d  <= r_ls;
            r_dval  <= 1'b0;
            r_sof   <= 1'b0;
            r_eol   <= 1'b0;
            r_eof   <= 1'b0;

            if (!r_ls) begin
                r_ph      <= '0;
                r_in_line <= 1'b0;
            end else if (w_byte) begin
                r_in_line <= 1'b1;
                r_asm     <= w_asm_next;
                r_ph      <= (r_ph == PH_LAST) ? '0 : r_ph + PHW'(1);
            end

            // Pixels past the active width are still counted so an over-long line is flagged
            if (w_pix) begin
                if (r_x == X_MAX) r_x_ovf <= 1'b1;
                else              r_x     <= r_x + XW'(1);
                if (w_in_win) begin
                    r_data     <= w_asm_next;
                    r_dval     <= 1'b1;
                    r_x_cont   <= r_x;
                    r_y_cont   <= r_y;
                    r_sof      <= r_sof_pend;
                    r_sof_pend <= 1'b0;
                end
            end

            if (w_eol) begin
                r_eol <= 1'b1;
                if ((r_x != X_MAX) || (r_ph != '0) || r_x_ovf) r_line_err <= 1'b1;
                r_x     <= '0;
                r_x_ovf <= 1'b0;
                if (r_y == Y_MAX) r_y_ovf <= 1'b1;
                else              r_y     <= r_y + YW'(1);
            end

            case (r_state)
                S_IDLE: begin
                    if (bus.iSTART && !bus.iEND) begin
                        r_state  <= S_ARMED;
                        r_single <= bus.iSINGLE;
                        r_busy   <= 1'b1;
                    end
                end
                S_ARMED: begin
                    if (bus.iEND) begin
                        r_state <= S_IDLE;
                        r_stop  <= 1'b0;
                        r_busy  <= 1'b0;
                    end else if (w_fs) begin
                        r_state     <= S_CAPT;
                        r_frame_cnt <= r_frame_cnt + FCW'(1);
                        r_line_err  <= 1'b0;
                        r_x         <= '0;
                        r_y         <= '0;
                        r_x_ovf     <= 1'b0;
                        r_y_ovf     <= 1'b0;
                        r_in_line   <= 1'b0;
                        r_sof_pend  <= 1'b1;
                    end
                end
                S_CAPT: begin
                    // A stop request only takes effect at frame end so frames are never cut short
                    if (bus.iEND) r_stop <= 1'b1;
                    if (w_fe) begin
                        r_eof       <= 1'b1;
                        r_frame_err <= (r_y != Y_MAX) || r_y_ovf;
                        if (r_stop || bus.iEND || r_single) begin
                            r_state <= S_IDLE;
                            r_stop  <= 1'b0;
                            r_busy  <= 1'b0;
                        end else begin
                            r_state <= S_ARMED;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.oDATA       = r_data;
    assign bus.oDVAL       = r_dval;
    assign bus.oSOF        = r_sof;
    assign bus.oEOL        = r_eol;
    assign bus.oEOF        = r_eof;
    assign bus.oX_Cont     = r_x_cont;
    assign bus.oY_Cont     = r_y_cont;
    assign bus.oFrame_Cont = r_frame_cnt;
    assign bus.oBUSY       = r_busy;
    assign bus.oLINE_ERR   = r_line_err;
    assign bus.oFRAME_ERR  = r_frame_err;
endmodule

// File: tb/tb_cam_capture_ctrl.sv
// Directed bench for cam_capture_ctrl with a 4x2 window of 2-byte pixels.
module tb_cam_capture_ctrl;
    localparam int unsigned DW = 8, PB = 2, H = 4, V = 2, XW = 11, YW = 10, FCW = 32;

    logic iCLK = 1'b0;
    logic iRST = 1'b1;
    always #5 iCLK = ~iCLK;

    cam_capture_ctrl_if #(.DW(DW), .PIX_BYTES(PB), .XW(XW), .YW(YW), .FCW(FCW)) bus();

    cam_capture_ctrl #(
        .DW(DW), .PIX_BYTES(PB), .H_ACTIVE(H), .V_ACTIVE(V), .XW(XW), .YW(YW), .FCW(FCW)
    ) dut (
        .iCLK (iCLK),
        .iRST (iRST),
        .bus  (bus)
    );

    int checks = 0;
    int errors = 0;

    int          mon_pix = 0, mon_sof = 0, mon_stray = 0, mon_eol = 0, mon_eof = 0;
    logic [15:0] mon_data [256];
    int          mon_x    [256];
    int          mon_y    [256];
    logic        mon_sofv [256];

    // Record every strobe and marker seen on the falling edge
    always @(negedge iCLK) begin
        if (bus.oDVAL === 1'b1) begin
            if (mon_pix < 256) begin
                mon_data[mon_pix] = bus.oDATA;
                mon_x[mon_pix]    = int'(bus.oX_Cont);
                mon_y[mon_pix]    = int'(bus.oY_Cont);
                mon_sofv[mon_pix] = bus.oSOF;
            end
            mon_pix++;
        end
        if (bus.oSOF === 1'b1) begin
            mon_sof++;
            if (bus.oDVAL !== 1'b1) mon_stray++;
        end
        if (bus.oEOL === 1'b1) mon_eol++;
        if (bus.oEOF === 1'b1) mon_eof++;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Expected pixel k of line l: line bytes start at 0x11 + 0x10*l, first byte in the MSBs
    function automatic logic [15:0] exp_pix(input int l, input int k);
        int b;
        b = 'h11 + 16 * l + 2 * k;
        return {8'(b), 8'(b + 1)};
    endfunction

    task automatic do_reset();
        iRST        = 1'b0;
        bus.iDATA   = '0;
        bus.iFVAL   = 1'b1;
        bus.iLVAL   = 1'b0;
        bus.iSTART  = 1'b0;
        bus.iEND    = 1'b0;
        bus.iSINGLE = 1'b0;
        repeat (3) @(negedge iCLK);
        iRST = 1'b1;
        repeat (2) @(negedge iCLK);
    endtask

    task automatic pulse_start(input logic single);
        @(negedge iCLK);
        bus.iSTART  = 1'b1;
        bus.iSINGLE = single;
        @(negedge iCLK);
        bus.iSTART  = 1'b0;
        bus.iSINGLE = 1'b0;
        repeat (2) @(negedge iCLK);
    endtask

    task automatic pulse_end();
        @(negedge iCLK);
        bus.iEND = 1'b1;
        @(negedge iCLK);
        bus.iEND = 1'b0;
    endtask

    task automatic frame_start();
        @(negedge iCLK);
        bus.iFVAL = 1'b0;
        repeat (3) @(negedge iCLK);
    endtask

    task automatic frame_end();
        @(negedge iCLK);
        bus.iFVAL = 1'b1;
        repeat (4) @(negedge iCLK);
    endtask

    task automatic send_line(input int n, input int l);
        for (int i = 0; i < n; i++) begin
            @(negedge iCLK);
            bus.iLVAL = 1'b1;
            bus.iDATA = 8'('h11 + 16 * l + i);
        end
        @(negedge iCLK);
        bus.iLVAL = 1'b0;
        bus.iDATA = '0;
        repeat (4) @(negedge iCLK);
    endtask

    task automatic run_frame(input int nlines, input int len_first, input int len_rest);
        frame_start();
        for (int l = 0; l < nlines; l++) send_line((l == 0) ? len_first : len_rest, l);
        frame_end();
    endtask

    task automatic test_reset();
        int p0;
        do_reset();
        checks++;
        if (bus.oDATA !== 16'h0) begin
            errors++; $display("FAIL reset_data: got %h expected 0000", bus.oDATA);
        end
        checks++;
        if ({bus.oDVAL, bus.oSOF, bus.oEOL, bus.oEOF, bus.oBUSY, bus.oLINE_ERR, bus.oFRAME_ERR} !== 7'b0) begin
            errors++; $display("FAIL reset_flags: got %b expected 0000000",
                {bus.oDVAL, bus.oSOF, bus.oEOL, bus.oEOF, bus.oBUSY, bus.oLINE_ERR, bus.oFRAME_ERR});
        end
        checks++;
        if ({bus.oX_Cont, bus.oY_Cont, bus.oFrame_Cont} !== '0) begin
            errors++; $display("FAIL reset_counters: got x=%0d y=%0d f=%0d expected 0",
                bus.oX_Cont, bus.oY_Cont, bus.oFrame_Cont);
        end

        // Reset asserted in the middle of a line, away from the clock edge
        pulse_start(1'b0);
        frame_start();
        for (int i = 0; i < 6; i++) begin
            @(negedge iCLK);
            bus.iLVAL = 1'b1;
            bus.iDATA = 8'('h11 + i);
        end
        repeat (3) @(negedge iCLK);
        checks++;
        if (bus.oDATA !== 16'h1516 || bus.oFrame_Cont !== 32'd1) begin
            errors++; $display("FAIL pre_reset_state: got data=%h f=%0d expected 1516 1", bus.oDATA, bus.oFrame_Cont);
        end
        #2 iRST = 1'b0;
        #1;
        checks++;
        if (bus.oDATA !== 16'h0 || {bus.oX_Cont, bus.oY_Cont, bus.oFrame_Cont} !== '0) begin
            errors++; $display("FAIL async_reset_data: got data=%h x=%0d f=%0d expected 0", bus.oDATA, bus.oX_Cont, bus.oFrame_Cont);
        end
        checks++;
        if ({bus.oDVAL, bus.oSOF, bus.oEOL, bus.oEOF, bus.oBUSY, bus.oLINE_ERR, bus.oFRAME_ERR} !== 7'b0) begin
            errors++; $display("FAIL async_reset_flags: got %b expected 0000000",
                {bus.oDVAL, bus.oSOF, bus.oEOL, bus.oEOF, bus.oBUSY, bus.oLINE_ERR, bus.oFRAME_ERR});
        end
        @(negedge iCLK);
        bus.iLVAL = 1'b0;
        bus.iFVAL = 1'b1;
        iRST      = 1'b1;
        repeat (2) @(negedge iCLK);

        // No capture until re-armed
        p0 = mon_pix;
        run_frame(2, 8, 8);
        checks++;
        if (mon_pix - p0 !== 0 || bus.oFrame_Cont !== 32'd0 || bus.oBUSY !== 1'b0) begin
            errors++; $display("FAIL no_capture_after_reset: got pix=%0d f=%0d busy=%b expected 0 0 0",
                mon_pix - p0, bus.oFrame_Cont, bus.oBUSY);
        end

        // Start and stop together in IDLE: stop wins
        @(negedge iCLK);
        bus.iSTART = 1'b1;
        bus.iEND   = 1'b1;
        @(negedge iCLK);
        bus.iSTART = 1'b0;
        bus.iEND   = 1'b0;
        @(negedge iCLK);
        checks++;
        if (bus.oBUSY !== 1'b0) begin
            errors++; $display("FAIL start_end_same_cycle: got busy=%b expected 0", bus.oBUSY);
        end
        p0 = mon_pix;
        run_frame(2, 8, 8);
        checks++;
        if (mon_pix - p0 !== 0 || bus.oFrame_Cont !== 32'd0) begin
            errors++; $display("FAIL start_end_no_capture: got pix=%0d f=%0d expected 0 0", mon_pix - p0, bus.oFrame_Cont);
        end
    endtask

    task automatic test_basic_frame();
        int p0, s0, e0, f0, st0;
        do_reset();
        pulse_start(1'b0);
        p0 = mon_pix; s0 = mon_sof; e0 = mon_eol; f0 = mon_eof; st0 = mon_stray;
        run_frame(2, 8, 8);
        checks++;
        if (mon_pix - p0 !== 8) begin
            errors++; $display("FAIL basic_pix_count: got %0d expected 8", mon_pix - p0);
        end
        for (int i = 0; i < 8; i++) begin
            checks++;
            if (mon_data[p0+i] !== exp_pix(i / 4, i % 4) || mon_x[p0+i] !== i % 4 || mon_y[p0+i] !== i / 4
                || mon_sofv[p0+i] !== (i == 0)) begin
                errors++; $display("FAIL basic_pix%0d: got data=%h x=%0d y=%0d sof=%b expected %h %0d %0d %b",
                    i, mon_data[p0+i], mon_x[p0+i], mon_y[p0+i], mon_sofv[p0+i],
                    exp_pix(i / 4, i % 4), i % 4, i / 4, (i == 0));
            end
        end
        checks++;
        if (mon_eol - e0 !== 2 || mon_eof - f0 !== 1 || mon_sof - s0 !== 1 || mon_stray - st0 !== 0) begin
            errors++; $display("FAIL basic_markers: got eol=%0d eof=%0d sof=%0d stray=%0d expected 2 1 1 0",
                mon_eol - e0, mon_eof - f0, mon_sof - s0, mon_stray - st0);
        end
        checks++;
        if (bus.oFrame_Cont !== 32'd1 || bus.oLINE_ERR !== 1'b0 || bus.oFRAME_ERR !== 1'b0 || bus.oBUSY !== 1'b1) begin
            errors++; $display("FAIL basic_status: got f=%0d le=%b fe=%b busy=%b expected 1 0 0 1",
                bus.oFrame_Cont, bus.oLINE_ERR, bus.oFRAME_ERR, bus.oBUSY);
        end
    endtask

    task automatic test_continuous();
        int p0, f0;
        do_reset();
        pulse_start(1'b0);
        run_frame(2, 8, 8);
        run_frame(2, 8, 8);
        checks++;
        if (bus.oFrame_Cont !== 32'd2 || bus.oBUSY !== 1'b1) begin
            errors++; $display("FAIL cont_two_frames: got f=%0d busy=%b expected 2 1", bus.oFrame_Cont, bus.oBUSY);
        end
        p0 = mon_pix; f0 = mon_eof;
        frame_start();
        send_line(8, 0);
        pulse_end();
        send_line(8, 1);
        checks++;
        if (bus.oBUSY !== 1'b1) begin
            errors++; $display("FAIL cont_busy_before_fe: got %b expected 1", bus.oBUSY);
        end
        frame_end();
        checks++;
        if (mon_pix - p0 !== 8 || mon_eof - f0 !== 1 || bus.oBUSY !== 1'b0 || bus.oFrame_Cont !== 32'd3) begin
            errors++; $display("FAIL cont_stop_frame: got pix=%0d eof=%0d busy=%b f=%0d expected 8 1 0 3",
                mon_pix - p0, mon_eof - f0, bus.oBUSY, bus.oFrame_Cont);
        end
        p0 = mon_pix; f0 = mon_eof;
        run_frame(2, 8, 8);
        checks++;
        if (mon_pix - p0 !== 0 || mon_eof - f0 !== 0 || bus.oFrame_Cont !== 32'd3) begin
            errors++; $display("FAIL cont_after_stop: got pix=%0d eof=%0d f=%0d expected 0 0 3",
                mon_pix - p0, mon_eof - f0, bus.oFrame_Cont);
        end
    endtask

    task automatic test_single_shot();
        int p0, f0;
        do_reset();
        pulse_start(1'b1);
        p0 = mon_pix; f0 = mon_eof;
        run_frame(2, 8, 8);
        run_frame(2, 8, 8);
        run_frame(2, 8, 8);
        checks++;
        if (mon_pix - p0 !== 8 || mon_eof - f0 !== 1 || bus.oFrame_Cont !== 32'd1 || bus.oBUSY !== 1'b0) begin
            errors++; $display("FAIL single_shot: got pix=%0d eof=%0d f=%0d busy=%b expected 8 1 1 0",
                mon_pix - p0, mon_eof - f0, bus.oFrame_Cont, bus.oBUSY);
        end
    endtask

    task automatic test_line_errors();
        int p0;
        do_reset();
        pulse_start(1'b0);
        p0 = mon_pix;
        run_frame(2, 7, 8);
        checks++;
        if (mon_pix - p0 !== 7 || bus.oLINE_ERR !== 1'b1 || bus.oFRAME_ERR !== 1'b0) begin
            errors++; $display("FAIL short_line: got pix=%0d le=%b fe=%b expected 7 1 0",
                mon_pix - p0, bus.oLINE_ERR, bus.oFRAME_ERR);
        end
        checks++;
        if (mon_data[p0+2] !== 16'h1516 || mon_data[p0+3] !== 16'h2122 || mon_x[p0+3] !== 0 || mon_y[p0+3] !== 1) begin
            errors++; $display("FAIL short_line_drop: got %h %h x=%0d y=%0d expected 1516 2122 0 1",
                mon_data[p0+2], mon_data[p0+3], mon_x[p0+3], mon_y[p0+3]);
        end
        frame_start();
        checks++;
        if (bus.oLINE_ERR !== 1'b0) begin
            errors++; $display("FAIL line_err_clear1: got %b expected 0", bus.oLINE_ERR);
        end
        p0 = mon_pix;
        send_line(10, 0);
        send_line(8, 1);
        frame_end();
        checks++;
        if (mon_pix - p0 !== 8 || bus.oLINE_ERR !== 1'b1 || mon_data[p0+3] !== 16'h1718 || mon_data[p0+4] !== 16'h2122) begin
            errors++; $display("FAIL long_line: got pix=%0d le=%b d3=%h d4=%h expected 8 1 1718 2122",
                mon_pix - p0, bus.oLINE_ERR, mon_data[p0+3], mon_data[p0+4]);
        end
        frame_start();
        checks++;
        if (bus.oLINE_ERR !== 1'b0) begin
            errors++; $display("FAIL line_err_clear2: got %b expected 0", bus.oLINE_ERR);
        end
        send_line(8, 0);
        send_line(8, 1);
        frame_end();
        checks++;
        if (bus.oLINE_ERR !== 1'b0 || bus.oFRAME_ERR !== 1'b0) begin
            errors++; $display("FAIL clean_frame: got le=%b fe=%b expected 0 0", bus.oLINE_ERR, bus.oFRAME_ERR);
        end
    endtask

    task automatic test_frame_errors();
        int p0, e0;
        do_reset();
        pulse_start(1'b0);
        p0 = mon_pix; e0 = mon_eol;
        run_frame(3, 8, 8);
        checks++;
        if (mon_pix - p0 !== 8 || mon_eol - e0 !== 3 || bus.oFRAME_ERR !== 1'b1 || bus.oLINE_ERR !== 1'b0) begin
            errors++; $display("FAIL tall_frame: got pix=%0d eol=%0d fe=%b le=%b expected 8 3 1 0",
                mon_pix - p0, mon_eol - e0, bus.oFRAME_ERR, bus.oLINE_ERR);
        end
        p0 = mon_pix;
        run_frame(1, 8, 8);
        checks++;
        if (mon_pix - p0 !== 4 || bus.oFRAME_ERR !== 1'b1) begin
            errors++; $display("FAIL short_frame: got pix=%0d fe=%b expected 4 1", mon_pix - p0, bus.oFRAME_ERR);
        end
        run_frame(2, 8, 8);
        checks++;
        if (bus.oFRAME_ERR !== 1'b0 || bus.oFrame_Cont !== 32'd3) begin
            errors++; $display("FAIL frame_err_recover: got fe=%b f=%0d expected 0 3", bus.oFRAME_ERR, bus.oFrame_Cont);
        end
    endtask

    initial begin
        test_reset();
        test_basic_frame();
        test_continuous();
        test_single_shot();
        test_line_errors();
        test_frame_errors();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/cam_capture_ctrl.md
Name: cam_capture_ctrl

Overview:
Parametrised camera-bus capture front end for OV7670-class sensors. It converts the byte stream qualified by frame-valid/line-valid into whole pixels of PIX_BYTES bytes each, with one-cycle pixel strobes and X/Y coordinates. It adds start/stop/single-shot arming, SOF/EOL/EOF markers and geometry-error flags. It sits between the sensor input registers and the frame-buffer write path, all in the pixel-clock domain.

Parameters:
DW, 8, sensor data bus width in bits
PIX_BYTES, 2, bytes per pixel (1 = raw/Y, 2 = RGB565/YUV422 pair); legal values 1..4
H_ACTIVE, 640, expected pixels per line
V_ACTIVE, 480, expected lines per frame
XW, 11, X counter width; must hold H_ACTIVE
YW, 10, Y counter width; must hold V_ACTIVE
FCW, 32, frame counter width

Ports:
iCLK  in  1  pixel clock; all logic on posedge
iRST  in  1  asynchronous, active-low reset
iDATA  in  DW  sensor data byte
iFVAL  in  1  sensor VSYNC, active-high pulse between frames
iLVAL  in  1  sensor HREF, high while line bytes are valid
iSTART  in  1  arm-capture pulse
iEND  in  1  stop-capture pulse
iSINGLE  in  1  sampled with iSTART; 1 = capture one frame only
oDATA  out  PIX_BYTES*DW  assembled pixel; first byte in the MSBs
oDVAL  out  1  one-cycle strobe per in-window pixel
oSOF  out  1  high together with oDVAL on pixel (0,0)
oEOL  out  1  one-cycle pulse at the end of each captured line
oEOF  out  1  one-cycle pulse at the end of a captured frame
oX_Cont  out  XW  column of the current oDATA
oY_Cont  out  YW  row of the current oDATA
oFrame_Cont  out  FCW  count of accepted frames
oBUSY  out  1  state is not IDLE
oLINE_ERR  out  1  sticky: some line length != H_ACTIVE in this frame
oFRAME_ERR  out  1  sticky: last frame line count != V_ACTIVE

Behaviour:
- Reset: all outputs 0; state IDLE; internal pipeline, phase and counters cleared.
- Edge detect: iFVAL is registered to pFVAL.
  - FS (frame start) = pFVAL & ~iFVAL.
  - FE (frame end) = ~pFVAL & iFVAL.
- State machine:
  - IDLE: iSTART → ARMED; latch iSINGLE into single_q.
  - ARMED: FS → CAPT; oFrame_Cont +1; clear oLINE_ERR, x, y and the SOF-pending flag is set. iEND → IDLE.
  - CAPT, on FE: pulse oEOF; oFRAME_ERR <= (y != V_ACTIVE).
    - If stop_q or single_q → IDLE.
    - Otherwise → ARMED; the following FS is handled by ARMED.
  - CAPT, on iEND: set stop_q; the current frame completes and the block goes IDLE at FE. No partial frames are ever produced.
  - iSTART and iEND in the same cycle: iEND wins. iSTART in ARMED/CAPT is ignored. stop_q is cleared on entry to IDLE.
- Input stage: iDATA and iLVAL are registered to dS and lS every cycle.
- Byte phase counter ph (0..PIX_BYTES-1):
  - Advances on each cycle with lS=1 in CAPT and wraps to 0.
  - Forced to 0 whenever lS=0.
  - Bytes are shifted into an assembly register MSB-first.
- Pixel strobe: when lS=1 and ph=PIX_BYTES-1, oDATA is loaded on the next edge.
  - oDVAL=1 for that cycle, only if x<H_ACTIVE and y<V_ACTIVE.
  - Latency: final byte on iDATA at edge n → oDATA/oDVAL valid after edge n+2.
  - x increments per completed pixel, saturating at H_ACTIVE; oX_Cont/oY_Cont hold the coordinates of the emitted pixel.
- End of line: falling edge of lS while in CAPT with x != 0.
  - Pulse oEOL.
  - If x != H_ACTIVE, or the line ended mid-pixel (ph != 0), set oLINE_ERR.
  - x <= 0; y increments, saturating at V_ACTIVE.
  - Trailing partial-pixel bytes are dropped.
- Pixels beyond H_ACTIVE and lines beyond V_ACTIVE: counted for error purposes but never strobed.
- oSOF: asserted with the first oDVAL after entering CAPT, then cleared.
- oFrame_Cont wraps modulo 2^FCW.
- Outside CAPT: oDVAL/oEOL/oEOF stay 0; oDATA holds its last value.
- LVAL high at the FS cycle: bytes before the first lS rising edge after FS are ignored (a line starts only on a rising edge of lS).

Test Plan:
- PIX_BYTES=2, H=4, V=2: iSTART, then FS, 2 lines of bytes 0x11..0x18 → oDVAL×8; oDATA 0x1112,0x1314,…; oSOF on first; oEOL×2; oEOF×1; oFrame_Cont=1; no errors.
- Continuous mode, 3 frames → oFrame_Cont=3; oBUSY stays 1. iEND mid-frame 3 → frame 3 completes (oEOF) then oBUSY=0; a later FS produces nothing.
- iSINGLE=1 with iSTART → exactly one frame, then IDLE; oFrame_Cont=1 after a further 2 FS edges.
- Line of 7 bytes with H=4, PIX_BYTES=2 → 3 pixels strobed, last byte dropped, oLINE_ERR=1. Line of 10 bytes → 4 strobed, oLINE_ERR=1. Both cleared at the next FS.
- Frame of 3 lines with V=2 → third line not strobed; oFRAME_ERR=1 at FE. Frame of 1 line → oFRAME_ERR=1.
- iRST low mid-line → all outputs 0 asynchronously; after release, no capture until iSTART, FS. iSTART+iEND same cycle in IDLE → stays IDLE.
